route_compute: RTL and testbench

Per-input-port route computation unit that sits between a router input buffer and the switch allocator. It is the lookup side of `routing_table`: on each head flit it drives `table_addr` with the destination node, registers the returned direction, and holds that direction for every flit of the packet until the tail leaves. Flits pass through a one-entry output register with a valid/ready handshake on both sides.

---
 rtl/route_compute.sv | 115 +++++++++++
 tb/tb_route_compute.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/route_compute.sv
// Route computation for one router input port: looks up the head flit's
// destination, then tags every flit of that packet with the same direction.
module route_compute #(
    parameter int NODE_ID   = 0,
    parameter int SIZE      = 4,
    parameter int BITS_DIR  = 3,
    parameter int FLIT_W    = 16,
    parameter int PKT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [FLIT_W-1:0]    in_flit,
    output logic                 in_ready,
    output logic [SIZE-1:0]      table_addr,
    input  logic [BITS_DIR-1:0]  table_data,
    output logic                 out_valid,
    output logic [FLIT_W-1:0]    out_flit,
    output logic [BITS_DIR-1:0]  out_dir,
    input  logic                 out_ready,
    output logic                 err_drop,
    output logic                 err_head,
    output logic [PKT_CNT_W-1:0] pkt_count
);

    // NODE_ID only tags this port instance; it never influences routing.
    if (NODE_ID < 0) begin : g_node_id_negative_unsupported
    end

    typedef enum logic [2:0] {IDLE, LOOKUP, HEAD, BODY, DRAIN} state_t;

    localparam logic [PKT_CNT_W-1:0] CNT_ONE = PKT_CNT_W'(1);

    state_t state, state_nxt;
    logic   in_fire, out_fire, in_head, in_tail;

    assign in_head  = in_flit[FLIT_W-1];
    assign in_tail  = in_flit[FLIT_W-2];
    assign in_ready = (state == IDLE) || ((state == BODY) && (!out_valid || out_ready));
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire && in_head) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = HEAD;
            HEAD:    if (out_fire) state_nxt = out_flit[FLIT_W-2] ? IDLE : BODY;
            BODY:    if (in_fire && in_tail) state_nxt = DRAIN;
            DRAIN:   if (out_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_flit   <= '0;
            out_dir    <= '0;
            table_addr <= '0;
            pkt_count  <= '0;
            err_drop   <= 1'b0;
            err_head   <= 1'b0;
        end else begin
            err_drop <= 1'b0;
            err_head <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        if (in_head) begin
                            out_flit   <= in_flit;
                            out_valid  <= 1'b0;
                            table_addr <= in_flit[SIZE-1:0];
                        end else begin
                            err_drop <= 1'b1;
                        end
                    end
                end
                LOOKUP: begin
                    out_dir   <= table_data;
                    out_valid <= 1'b1;
                end
                HEAD: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        if (out_flit[FLIT_W-2]) pkt_count <= pkt_count + CNT_ONE;
                    end
                end
                // A stray head inside a packet is flagged but carried as body.
                BODY: begin
                    if (in_fire) begin
                        out_flit  <= in_flit;
                        out_valid <= 1'b1;
                        err_head  <= in_head;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        pkt_count <= pkt_count + CNT_ONE;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_route_compute.sv
// Directed bench for route_compute with a small routing-table model for node 5.
module tb_route_compute;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_flit;
    logic        in_ready;
    logic [3:0]  table_addr;
    logic [2:0]  table_data;
    logic        out_valid;
    logic [15:0] out_flit;
    logic [2:0]  out_dir;
    logic        out_ready;
    logic        err_drop;
    logic        err_head;
    logic [7:0]  pkt_count;

    int checks   = 0;
    int failures = 0;
    logic [15:0] seen[$];

    // Narrow counter so that the wrap-around is reachable in a short run.
    route_compute #(
        .NODE_ID(5), .SIZE(4), .BITS_DIR(3), .FLIT_W(16), .PKT_CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_flit(in_flit),
        .in_ready(in_ready), .table_addr(table_addr), .table_data(table_data),
        .out_valid(out_valid), .out_flit(out_flit), .out_dir(out_dir),
        .out_ready(out_ready), .err_drop(err_drop), .err_head(err_head),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] tbl(input logic [3:0] a);
        case (a)
            4'd9:    return 3'd2;
            4'd0:    return 3'd3;
            4'd6:    return 3'd7;
            4'd3:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    assign table_data = tbl(table_addr);

    always @(posedge clk)
        if (!reset && out_valid && out_ready) seen.push_back(out_flit);

    function automatic logic [15:0] mk(input logic h, input logic t, input logic [13:0] p);
        return {h, t, p};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] h, b1, b2, t;
        reset = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_flit",  32'(out_flit), 0);
        chk("rst_out_dir",   32'(out_dir), 0);
        chk("rst_table_addr", 32'(table_addr), 0);
        chk("rst_pkt_count", 32'(pkt_count), 0);
        chk("rst_in_ready",  32'(in_ready), 1);
        chk("rst_errs",      32'({err_drop, err_head}), 0);
        reset = 1'b0;
        step();

        // single-flit packet to destination 9
        h = mk(1'b1, 1'b1, 14'h1239);
        in_valid = 1'b1; in_flit = h;
        step();
        in_valid = 1'b0;
        chk("t1_table_addr", 32'(table_addr), 9);
        chk("t1_valid_lookup", 32'(out_valid), 0);
        chk("t1_ready_lookup", 32'(in_ready), 0);
        step();
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_dir", 32'(out_dir), 2);
        chk("t1_out_flit", 32'(out_flit), 32'(h));
        chk("t1_ready_head", 32'(in_ready), 0);
        out_ready = 1'b1;
        step();
        chk("t1_valid_done", 32'(out_valid), 0);
        chk("t1_pkt_count", 32'(pkt_count), 1);
        chk("t1_idle_ready", 32'(in_ready), 1);

        // four-flit packet to destination 0, out_ready held high
        h = mk(1'b1, 1'b0, 14'h0100); b1 = mk(1'b0, 1'b0, 14'h0AA1);
        b2 = mk(1'b0, 1'b0, 14'h0BB2); t = mk(1'b0, 1'b1, 14'h0CC3);
        seen.delete();
        in_valid = 1'b1; in_flit = h;
        step();
        in_flit = b1;
        chk("t2_ready_lookup", 32'(in_ready), 0);
        chk("t2_table_addr", 32'(table_addr), 0);
        step();
        chk("t2_ready_head", 32'(in_ready), 0);
        chk("t2_dir_head", 32'(out_dir), 3);
        chk("t2_flit_head", 32'(out_flit), 32'(h));
        step();
        chk("t2_body_ready", 32'(in_ready), 1);
        step();
        chk("t2_flit_b1", 32'(out_flit), 32'(b1));
        chk("t2_dir_b1", 32'(out_dir), 3);
        in_flit = b2;
        step();
        chk("t2_flit_b2", 32'(out_flit), 32'(b2));
        chk("t2_valid_b2", 32'(out_valid), 1);
        chk("t2_dir_b2", 32'(out_dir), 3);
        in_flit = t;
        step();
        in_valid = 1'b0;
        chk("t2_flit_tail", 32'(out_flit), 32'(t));
        chk("t2_dir_tail", 32'(out_dir), 3);
        chk("t2_ready_drain", 32'(in_ready), 0);
        step();
        chk("t2_pkt_count", 32'(pkt_count), 2);
        chk("t2_valid_done", 32'(out_valid), 0);
        chk("t2_seen_count", 32'(seen.size()), 4);
        if (seen.size() == 4) begin
            chk("t2_seen0", 32'(seen[0]), 32'(h));
            chk("t2_seen1", 32'(seen[1]), 32'(b1));
            chk("t2_seen2", 32'(seen[2]), 32'(b2));
            chk("t2_seen3", 32'(seen[3]), 32'(t));
        end

        // backpressure in BODY; second body flit carries a stray head bit
        h = mk(1'b1, 1'b0, 14'h0206); b1 = mk(1'b0, 1'b0, 14'h0D01);
        b2 = mk(1'b1, 1'b0, 14'h0E02); t = mk(1'b0, 1'b1, 14'h0F03);
        seen.delete();
        in_valid = 1'b1; in_flit = h;
        step();
        in_flit = b1;
        step();
        chk("t3_dir_passthrough", 32'(out_dir), 7);
        step();
        step();
        chk("t3_flit_b1", 32'(out_flit), 32'(b1));
        out_ready = 1'b0; in_flit = b2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_flit", 32'(out_flit), 32'(b1));
            chk("t3_hold_dir", 32'(out_dir), 7);
            chk("t3_hold_ready", 32'(in_ready), 0);
            chk("t3_hold_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        step();
        chk("t3_flit_b2", 32'(out_flit), 32'(b2));
        chk("t3_err_head", 32'(err_head), 1);
        in_flit = t;
        step();
        in_valid = 1'b0;
        chk("t3_err_head_end", 32'(err_head), 0);
        chk("t3_flit_tail", 32'(out_flit), 32'(t));
        step();
        chk("t3_pkt_count", 32'(pkt_count), 3);
        chk("t3_seen_count", 32'(seen.size()), 4);
        if (seen.size() == 4) begin
            chk("t3_seen1", 32'(seen[1]), 32'(b1));
            chk("t3_seen2", 32'(seen[2]), 32'(b2));
            chk("t3_seen3", 32'(seen[3]), 32'(t));
        end

        // headless flit in IDLE
        in_valid = 1'b1; in_flit = mk(1'b0, 1'b0, 14'h0033);
        step();
        in_valid = 1'b0;
        chk("t4_err_drop", 32'(err_drop), 1);
        chk("t4_valid", 32'(out_valid), 0);
        chk("t4_ready_idle", 32'(in_ready), 1);
        chk("t4_addr_kept", 32'(table_addr), 6);
        step();
        chk("t4_err_drop_end", 32'(err_drop), 0);
        chk("t4_still_idle", 32'(in_ready), 1);

        // reset after two of four flits
        h = mk(1'b1, 1'b0, 14'h0303); b1 = mk(1'b0, 1'b0, 14'h0111);
        in_valid = 1'b1; in_flit = h;
        step();
        in_flit = b1;
        step();
        chk("t5_dir", 32'(out_dir), 4);
        step();
        step();
        in_valid = 1'b0;
        chk("t5_flit_b1", 32'(out_flit), 32'(b1));
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_count", 32'(pkt_count), 0);
        chk("t5_rst_ready", 32'(in_ready), 1);
        step();
        reset = 1'b0;
        step();
        h = mk(1'b1, 1'b1, 14'h0459);
        in_valid = 1'b1; in_flit = h;
        step();
        in_valid = 1'b0;
        chk("t5_new_addr", 32'(table_addr), 9);
        step();
        chk("t5_new_dir", 32'(out_dir), 2);
        chk("t5_new_valid", 32'(out_valid), 1);
        step();
        chk("t5_new_count", 32'(pkt_count), 1);

        // counter wrap: 254 more single-flit packets reach 0xFF, one more wraps
        for (int i = 0; i < 255; i++) begin
            in_valid = 1'b1; in_flit = mk(1'b1, 1'b1, 14'(i));
            step();
            in_valid = 1'b0;
            step();
            step();
            if (i == 253) chk("t6_count_max", 32'(pkt_count), 32'hFF);
        end
        chk("t6_count_wrap", 32'(pkt_count), 0);
        chk("t6_idle_end", 32'(in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
